conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 IMG_W, default 28, image width in pixels.
REQ-002 IMG_H, default 28, image height in pixels.
REQ-003 K, default 5, square window edge; the window carries K*K = 25 elements.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pix_in  input  8  one Float8 pixel; frames arrive in row-major order.
REQ-007 pix_valid  input  1  pix_in carries a valid pixel.
REQ-008 pix_ready  output  1  block accepts pix_in this cycle.
REQ-009 win_out  output  K*K*8  window bus; element i occupies bits [8i+7:8i].
REQ-010 win_valid  output  1  win_out holds a valid window.
REQ-011 win_ready  input  1  downstream accepts win_out this cycle.
REQ-012 frame_done  output  1  one-cycle pulse when the last window of a frame is accepted.

Function
REQ-013 A pixel is accepted on any cycle where pix_valid and pix_ready are both 1; no other input is sampled.
REQ-014 pix_ready SHALL equal (!win_valid || win_ready): combinational, no bubble under continuous flow.
REQ-015 Column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) advance per accepted pixel. x wraps to 0 and y increments at x = IMG_W-1. Both wrap to 0 after pixel (IMG_H-1, IMG_W-1).
REQ-016 The line buffer is a shift register of (K-1)*IMG_W+K entries of 8 bits. It shifts exactly once per accepted pixel and is never written otherwise.
REQ-017 A window is produced when an accepted pixel has x >= K-1 and y >= K-1; with defaults that is 24x24 = 576 windows per frame.
REQ-018 Window element i = r*K+c (r, c in 0..K-1) SHALL be pixel (y-K+1+r, x-K+1+c). Element 0 is the top-left pixel; element K*K-1 is the pixel just accepted.
REQ-019 Latency: win_out/win_valid are registered and valid on the cycle after the producing pixel is accepted.
REQ-020 win_valid, once set, holds with win_out stable until win_ready=1.
REQ-021 On accept (win_valid && win_ready) with no new window produced in the same cycle, win_valid clears.
REQ-022 Simultaneous accept of a window and a pixel that produces a new window SHALL load the new window with win_valid staying 1, giving one window per cycle at full throughput.
REQ-023 Pixels with x < K-1 or y < K-1 shift into the buffer but produce no window and do not disturb a pending window.
REQ-024 frame_done pulses for one cycle on acceptance of the window produced by pixel (IMG_H-1, IMG_W-1). It is 0 otherwise.
REQ-025 Back-to-back frames need no idle gap; the first K-1 rows of a new frame are used as fresh warm-up and never combine with the old frame.

Reset
REQ-026 On rst: x=0, y=0, win_valid=0, frame_done=0, win_out=0. pix_ready reads 1 while in reset.
REQ-027 Line buffer contents need not be cleared; REQ-017 guarantees no stale data reaches win_out.
REQ-028 Reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).

Structure
REQ-029 IMG_W, IMG_H, K and the Float8 width (8) SHALL live in the shared TPU package/header, which the 25-element convolution unit also uses.
REQ-030 The shift register SHALL be a sub-module conv_line_buffer with ports clk, shift_en, din[7:0] and a flat tap bus of the K*K window positions. conv_window_gen holds the counters, handshake and output register.
REQ-031 The win_out element ordering SHALL match the kernel-weight ordering of the convolution unit, so the two buses connect bit-for-bit.

Verification
REQ-032 Continuous flow, default params, pix_in = (y*28+x) mod 256, win_ready=1. Required: 576 windows. The first window follows pixel (4,4) by one cycle and has element 0=0x00, element 4=0x04, element 24=0x74. frame_done pulses once.
REQ-033 win_ready=0 for 10 cycles while a window is pending. Required: win_out stable, win_valid=1, pix_ready=0, and no pixel is lost once win_ready returns.
REQ-034 Random pix_valid/win_ready toggling (50%) over 3 frames. Required: window stream matches a software 5x5 sliding-window model exactly, with 1728 windows and 3 frame_done pulses.
REQ-035 Row wrap. Required: the pixel at (5,3) produces no window; the pixel at (5,4) produces a window with element 0=pixel(1,0).
REQ-036 Assert rst at pixel (10,10), then release and send a full frame. Required: outputs zero during reset, and exactly 576 correct windows after release.
REQ-037 Two frames back-to-back with no gap. Required: the first window of frame 2 contains only frame-2 pixels.

Source files
------------

// File: rtl/conv_window_gen_pkg.sv
// Shared TPU dimensions: image geometry, window edge and Float8 pixel width.
// The convolution unit imports the same values so its weight bus lines up with win_out.
package conv_window_gen_pkg;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int PIX_W = 8;
endpackage

// File: rtl/conv_line_buffer.sv
// Pixel shift register spanning K-1 full rows plus K pixels; taps expose the KxK window
// as it will stand once din is shifted in, so the window register can load in the same cycle.
module conv_line_buffer
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_W = conv_window_gen_pkg::IMG_W,
  parameter int K     = conv_window_gen_pkg::K
) (
  input  logic                   clk,
  input  logic                   shift_en,
  input  logic [PIX_W-1:0]       din,
  output logic [K*K*PIX_W-1:0]   taps
);
  // Entry 0 of the (K-1)*IMG_W+K chain is din itself; the rest is storage.
  localparam int DEPTH = (K-1)*IMG_W + K;

  logic [PIX_W-1:0] sr_q [DEPTH-1];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      sr_q[0] <= din;
      for (int i = 1; i < DEPTH-1; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      localparam int AGE = (K-1-r)*IMG_W + (K-1-c);
      if (AGE == 0) begin : g_new
        assign taps[(r*K+c)*PIX_W +: PIX_W] = din;
      end else begin : g_old
        assign taps[(r*K+c)*PIX_W +: PIX_W] = sr_q[AGE-1];
      end
    end
  end
endmodule

// File: rtl/conv_window_gen.sv
// KxK sliding-window generator over a row-major pixel stream; window registered one cycle
// after its producing pixel, held until win_ready, with pix_ready = !win_valid || win_ready.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_W = conv_window_gen_pkg::IMG_W,
  parameter int IMG_H = conv_window_gen_pkg::IMG_H,
  parameter int K     = conv_window_gen_pkg::K
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [K*K*PIX_W-1:0] win_out,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 frame_done
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W-1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H-1);
  localparam logic [XW-1:0] X_FIRST = XW'(K-1);
  localparam logic [YW-1:0] Y_FIRST = YW'(K-1);

  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   win_valid_q, win_valid_d;
  logic                   win_last_q, win_last_d;
  logic [K*K*PIX_W-1:0]   win_q, win_d;
  logic [K*K*PIX_W-1:0]   taps;
  logic                   accept, produce, at_last;

  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign produce   = accept && (x_q >= X_FIRST) && (y_q >= Y_FIRST);
  assign at_last   = (x_q == X_LAST) && (y_q == Y_LAST);

  conv_line_buffer #(.IMG_W(IMG_W), .K(K)) u_line_buffer (
    .clk      (clk),
    .shift_en (accept),
    .din      (pix_in),
    .taps     (taps)
  );

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_d       = win_q;
    if (accept) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
    // A new window overrides the clear so full-rate flow never bubbles.
    if (produce) begin
      win_valid_d = 1'b1;
      win_last_d  = at_last;
      win_d       = taps;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_q       <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_q       <= win_d;
    end
  end

  assign win_out    = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = win_valid_q && win_ready && win_last_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: image-array model builds each expected 5x5 window from stored
// pixels; a negedge monitor compares handshake and window bus every cycle.
module tb_conv_window_gen;
  localparam int W = 28;
  localparam int H = 28;
  localparam int KK = 5;
  localparam int NPIX = W*H;

  typedef struct {
    logic [KK*KK*8-1:0] w;
    bit                 last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           pix_in;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [KK*KK*8-1:0]   win_out;
  logic                 win_valid;
  logic                 win_ready;
  logic                 frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int win_cnt = 0;
  int fd_cnt = 0;
  int first_valid_cyc = -1;
  int acc44_cyc = -1;
  int mx = 0;
  int my = 0;
  logic [7:0] img [H][W];
  exp_t expq[$];
  logic [KK*KK*8-1:0] wlog[$];

  conv_window_gen dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pixval(input int idx);
    int f;
    int p;
    f = idx / NPIX;
    p = idx % NPIX;
    return 8'((p + 37*f) % 256);
  endfunction

  function automatic logic [KK*KK*8-1:0] build_win(input int y, input int x);
    logic [KK*KK*8-1:0] w;
    w = '0;
    for (int r = 0; r < KK; r++)
      for (int c = 0; c < KK; c++)
        w[(r*KK+c)*8 +: 8] = img[y-KK+1+r][x-KK+1+c];
    return w;
  endfunction

  // Reference model and per-cycle compare.
  always @(negedge clk) begin
    bit exp_ready;
    exp_t e;
    cyc++;
    if (rst) begin
      expq.delete();
      mx = 0;
      my = 0;
      chk("rst_win_valid", 256'(win_valid), 256'(0));
      chk("rst_frame_done", 256'(frame_done), 256'(0));
      chk("rst_win_out", 256'(win_out), 256'(0));
      chk("rst_pix_ready", 256'(pix_ready), 256'(1));
    end else begin
      exp_ready = (expq.size() == 0) || win_ready;
      chk("win_valid", 256'(win_valid), 256'(expq.size() != 0));
      chk("pix_ready", 256'(pix_ready), 256'(exp_ready));
      if (expq.size() != 0) chk("win_out", 256'(win_out), 256'(expq[0].w));
      chk("frame_done", 256'(frame_done),
          256'((expq.size() != 0) && win_ready && expq[0].last));
      if (win_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (win_valid && win_ready) begin
        wlog.push_back(win_out);
        win_cnt++;
        if (frame_done) fd_cnt++;
      end
      if (expq.size() != 0 && win_ready) void'(expq.pop_front());
      if (pix_valid && exp_ready) begin
        img[my][mx] = pix_in;
        if (my == 4 && mx == 4 && acc44_cyc < 0) acc44_cyc = cyc;
        if (mx >= KK-1 && my >= KK-1) begin
          e.w = build_win(my, mx);
          e.last = (mx == W-1) && (my == H-1);
          expq.push_back(e);
        end
        if (mx == W-1) begin
          mx = 0;
          my = (my == H-1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end
    end
  end

  // Present pixels start..start+n-1; returns at the negedge before the last pixel's accepting edge.
  task automatic run_pixels(input int start, input int n, input int pv_pct, input int wr_pct);
    int idx;
    int guard;
    idx = start;
    guard = 0;
    while (idx < start + n) begin
      @(posedge clk);
      #1;
      pix_valid = ($urandom_range(99) < pv_pct);
      win_ready = ($urandom_range(99) < wr_pct);
      pix_in = pixval(idx);
      @(negedge clk);
      if (pix_valid && pix_ready) idx++;
      guard++;
      if (guard > n*20 + 100) begin
        checks++;
        errors++;
        $display("FAIL pixel_timeout: sent %0d required %0d", idx - start, n);
        break;
      end
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_stats();
    win_cnt = 0;
    fd_cnt = 0;
    wlog.delete();
    first_valid_cyc = -1;
    acc44_cyc = -1;
  endtask

  initial begin
    rst = 1'b1;
    pix_in = 8'h00;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Continuous flow, one frame.
    clear_stats();
    run_pixels(0, NPIX, 100, 100);
    drain();
    chk("t1_windows", 256'(win_cnt), 256'(576));
    chk("t1_frame_done", 256'(fd_cnt), 256'(1));
    chk("t1_latency", 256'(first_valid_cyc - acc44_cyc), 256'(1));
    if (wlog.size() >= 25) begin
      chk("t1_w0_e0", 256'(wlog[0][7:0]), 256'(8'h00));
      chk("t1_w0_e4", 256'(wlog[0][39:32]), 256'(8'h04));
      chk("t1_w0_e24", 256'(wlog[0][199:192]), 256'(8'h74));
      chk("t1_row4_end_e24", 256'(wlog[23][199:192]), 256'(8'h8B));
      chk("t1_wrap_e0", 256'(wlog[24][7:0]), 256'(8'h1C));
      chk("t1_wrap_e24", 256'(wlog[24][199:192]), 256'(8'h90));
    end else begin
      chk("t1_log_size", 256'(wlog.size()), 256'(576));
    end

    // Downstream stall with a window pending from pixel (7,4).
    clear_stats();
    run_pixels(0, 201, 100, 100);
    @(posedge clk);
    #1;
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_in = pixval(201);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 256'(win_valid), 256'(1));
      chk("stall_pix_ready", 256'(pix_ready), 256'(0));
      chk("stall_e0", 256'(win_out[7:0]), 256'(8'h54));
      chk("stall_e4", 256'(win_out[39:32]), 256'(8'h58));
      chk("stall_e24", 256'(win_out[199:192]), 256'(8'hC8));
    end
    run_pixels(201, NPIX - 201, 100, 100);
    drain();
    chk("t2_windows", 256'(win_cnt), 256'(576));
    chk("t2_frame_done", 256'(fd_cnt), 256'(1));

    // Random handshakes over three frames.
    clear_stats();
    run_pixels(0, 3*NPIX, 50, 50);
    drain();
    chk("t3_windows", 256'(win_cnt), 256'(1728));
    chk("t3_frame_done", 256'(fd_cnt), 256'(3));

    // Reset at pixel (10,10), then a fresh frame.
    run_pixels(0, 10*W + 10, 100, 100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_in = pixval(10*W + 10);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pix_valid = 1'b0;
    clear_stats();
    run_pixels(0, NPIX, 100, 100);
    drain();
    chk("t4_windows", 256'(win_cnt), 256'(576));
    chk("t4_frame_done", 256'(fd_cnt), 256'(1));
    if (wlog.size() >= 1) chk("t4_w0_e24", 256'(wlog[0][199:192]), 256'(8'h74));

    // Two frames back-to-back.
    clear_stats();
    run_pixels(0, 2*NPIX, 100, 100);
    drain();
    chk("t5_windows", 256'(win_cnt), 256'(1152));
    chk("t5_frame_done", 256'(fd_cnt), 256'(2));
    if (wlog.size() >= 577) begin
      chk("t5_f2_e0", 256'(wlog[576][7:0]), 256'(8'h25));
      chk("t5_f2_e24", 256'(wlog[576][199:192]), 256'(8'h99));
    end else begin
      chk("t5_log_size", 256'(wlog.size()), 256'(1152));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
